// File: rtl/neighbor_table_scheduler_if.sv
// Requester-side bundle of the neighbor table scheduler: per-requester id/valid,
// one-hot accept, and the shared completion/status return.
interface neighbor_table_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ID_W-1:0] in_req_id;
  logic [NUM_REQ-1:0]           in_req_valid;
  logic [NUM_REQ-1:0]           out_req_ready;
  logic                         out_req_done;
  logic [IDX_W-1:0]             out_req_done_idx;
  logic [1:0]                   out_req_status;

  modport master (
    output in_req_id, in_req_valid,
    input  out_req_ready, out_req_done, out_req_done_idx, out_req_status
  );

  modport slave (
    input  in_req_id, in_req_valid,
    output out_req_ready, out_req_done, out_req_done_idx, out_req_status
  );
endinterface

// File: rtl/neighbor_table_scheduler.sv
// Round-robin front end for the neighbor table: each grant runs search-then-register
// and returns a status; table expiry events are queued in a small FWFT FIFO.
module neighbor_table_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int EVT_DEPTH = 4,
  parameter int ID_W      = 8
) (
  input  logic                   nocclk,
  input  logic                   rst_n,
  neighbor_table_scheduler_if.slave req,
  output logic [ID_W-1:0]        out_search_id,
  input  logic                   in_search_id_valid,
  output logic [ID_W-1:0]        out_register_id,
  output logic                   out_register_valid,
  input  logic                   in_register_ready,
  input  logic [ID_W-1:0]        in_invalid_id,
  input  logic                   in_invalid_id_valid,
  input  logic                   in_is_parent_id_invalid,
  output logic [ID_W-1:0]        out_evt_id,
  output logic                   out_evt_parent,
  output logic                   out_evt_valid,
  input  logic                   in_evt_ready,
  output logic                   out_evt_overflow
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(EVT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, REGISTER, DONE} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q;
  logic [IDX_W-1:0] idx_q, last_q, gnt_idx, cand;
  logic             gnt_any, accept;
  logic [1:0]       status_q, status_d;

  // First valid requester after the previous grant, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_q;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!gnt_any && req.in_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    status_d           = status_q;
    accept             = 1'b0;
    req.out_req_ready  = '0;
    req.out_req_done   = 1'b0;
    out_register_valid = 1'b0;
    case (state_q)
      IDLE: if (gnt_any) begin
        accept                     = 1'b1;
        req.out_req_ready[gnt_idx] = 1'b1;
        state_d                    = SEARCH;
      end
      SEARCH: begin
        if (in_search_id_valid) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (!in_register_ready) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else begin
          state_d  = REGISTER;
        end
      end
      REGISTER: begin
        out_register_valid = 1'b1;
        status_d           = 2'b00;
        state_d            = DONE;
      end
      DONE: begin
        req.out_req_done = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= '0;
      idx_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (accept) begin
        id_q   <= req.in_req_id[gnt_idx];
        idx_q  <= gnt_idx;
        last_q <= gnt_idx;
      end
    end
  end

  assign out_search_id        = id_q;
  assign out_register_id      = id_q;
  assign req.out_req_done_idx = idx_q;
  assign req.out_req_status   = status_q;

  // Expiry-event FIFO; a pop frees the slot for a same-cycle push when full.
  logic [ID_W:0]    mem [EVT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full, push, pop, ovf_q;

  assign full = (cnt == CNT_W'(EVT_DEPTH));
  assign pop  = (cnt != '0) && in_evt_ready;
  assign push = in_invalid_id_valid && (!full || pop);

  always_ff @(posedge nocclk) begin
    if (push) mem[wr_ptr] <= {in_invalid_id, in_is_parent_id_invalid};
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (in_invalid_id_valid && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign {out_evt_id, out_evt_parent} = mem[rd_ptr];
  assign out_evt_valid                = (cnt != '0);
  assign out_evt_overflow             = ovf_q;
endmodule

// File: tb/tb_neighbor_table_scheduler.sv
// Randomized bench for neighbor_table_scheduler against a transaction-level model
// of the neighbor table, the arbitration rule and the event queue.
module tb_neighbor_table_scheduler;
  localparam int NR  = 4;
  localparam int D   = 4;
  localparam int IW  = 8;
  localparam int CAP = 6;

  logic          nocclk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] out_search_id, out_register_id, in_invalid_id, out_evt_id;
  logic          search_hit, out_register_valid, reg_rdy;
  logic          in_invalid_id_valid, in_is_parent_id_invalid;
  logic          out_evt_parent, out_evt_valid, in_evt_ready, out_evt_overflow;

  always #5 nocclk = ~nocclk;

  neighbor_table_scheduler_if #(.NUM_REQ(NR), .ID_W(IW)) rq ();

  neighbor_table_scheduler #(.NUM_REQ(NR), .EVT_DEPTH(D), .ID_W(IW)) dut (
    .nocclk                  (nocclk),
    .rst_n                   (rst_n),
    .req                     (rq.slave),
    .out_search_id           (out_search_id),
    .in_search_id_valid      (search_hit),
    .out_register_id         (out_register_id),
    .out_register_valid      (out_register_valid),
    .in_register_ready       (reg_rdy),
    .in_invalid_id           (in_invalid_id),
    .in_invalid_id_valid     (in_invalid_id_valid),
    .in_is_parent_id_invalid (in_is_parent_id_invalid),
    .out_evt_id              (out_evt_id),
    .out_evt_parent          (out_evt_parent),
    .out_evt_valid           (out_evt_valid),
    .in_evt_ready            (in_evt_ready),
    .out_evt_overflow        (out_evt_overflow)
  );

  // Neighbor table model: membership set with a capacity and a space gate.
  bit   tbl [256];
  int   tbl_cnt;
  logic space_en;
  assign search_hit = tbl[out_search_id];
  assign reg_rdy    = space_en && (tbl_cnt < CAP);

  int          total = 0, bad = 0;
  int          last_g;
  logic [IW:0] evq [$];
  bit          ovf_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int next_gnt(input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++)
      if (m[(last_g + i) % NR]) return (last_g + i) % NR;
    return 0;
  endfunction

  task automatic clr_tbl();
    for (int i = 0; i < 256; i++) tbl[i] = 1'b0;
    tbl_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq.in_req_valid     = '0;
    in_invalid_id_valid = 1'b0;
    in_evt_ready        = 1'b0;
    @(posedge nocclk); #1;
    @(posedge nocclk); #1;
    rst_n  = 1'b1;
    last_g = NR - 1;
    evq.delete();
    ovf_m  = 1'b0;
    @(negedge nocclk);
    chk("rst_ready",  32'(rq.out_req_ready), 32'd0);
    chk("rst_done",   32'(rq.out_req_done), 32'd0);
    chk("rst_regv",   32'(out_register_valid), 32'd0);
    chk("rst_evtv",   32'(out_evt_valid), 32'd0);
    chk("rst_ovf",    32'(out_evt_overflow), 32'd0);
    chk("rst_status", 32'(rq.out_req_status), 32'd0);
    chk("rst_idx",    32'(rq.out_req_done_idx), 32'd0);
    chk("rst_sid",    32'(out_search_id), 32'd0);
    @(posedge nocclk); #1;
  endtask

  // One full request: grant, per-cycle strobe checks, completion.
  task automatic txn(input logic [NR-1:0] mask, input logic [NR-1:0][IW-1:0] ids,
                     input logic sp, output int st);
    int g, lat;
    logic [IW-1:0] id;
    rq.in_req_id    = ids;
    rq.in_req_valid = mask;
    space_en        = sp;
    g = next_gnt(mask);
    @(negedge nocclk);
    chk("grant", 32'(rq.out_req_ready), 32'(1 << g));
    id  = ids[g];
    st  = tbl[id] ? 1 : ((!sp || tbl_cnt >= CAP) ? 2 : 0);
    lat = (st == 0) ? 3 : 2;
    last_g = g;
    for (int k = 1; k <= lat; k++) begin
      @(posedge nocclk); #1;
      if (k == 1) rq.in_req_valid[g] = 1'b0;
      @(negedge nocclk);
      chk("rdy_busy", 32'(rq.out_req_ready), 32'd0);
      chk("reg_vld",  32'(out_register_valid), 32'(k == 2 && st == 0));
      chk("done",     32'(rq.out_req_done), 32'(k == lat));
      if (k == 1) chk("search_id", 32'(out_search_id), 32'(id));
      if (k == 2 && st == 0) chk("reg_id", 32'(out_register_id), 32'(id));
      if (k == lat) begin
        chk("done_idx", 32'(rq.out_req_done_idx), 32'(g));
        chk("status",   32'(rq.out_req_status), 32'(st));
      end
    end
    if (st == 0) begin
      tbl[id] = 1'b1;
      tbl_cnt++;
    end
    @(posedge nocclk); #1;
    rq.in_req_valid = '0;
  endtask

  task automatic evt_step(input bit push, input logic [IW-1:0] id, input bit par, input bit rdy);
    bit pop;
    in_invalid_id_valid     = push;
    in_invalid_id           = id;
    in_is_parent_id_invalid = par;
    in_evt_ready            = rdy;
    @(negedge nocclk);
    chk("evt_valid", 32'(out_evt_valid), 32'(evq.size() > 0));
    if (evq.size() > 0) chk("evt_head", 32'({out_evt_id, out_evt_parent}), 32'(evq[0]));
    chk("evt_ovf", 32'(out_evt_overflow), 32'(ovf_m));
    pop = (evq.size() > 0) && rdy;
    if (pop) void'(evq.pop_front());
    if (push) begin
      if (evq.size() < D) evq.push_back({id, par});
      else ovf_m = 1'b1;
    end
    @(posedge nocclk); #1;
    in_invalid_id_valid = 1'b0;
    in_evt_ready        = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR-1:0][IW-1:0] ids;
    int st, gap, seen;
    int rot [5];
    rst_n = 1'b0;
    rq.in_req_id = '0;
    rq.in_req_valid = '0;
    space_en = 1'b1;
    in_invalid_id = '0;
    in_invalid_id_valid = 1'b0;
    in_is_parent_id_invalid = 1'b0;
    in_evt_ready = 1'b0;
    clr_tbl();
    do_reset();

    // Register, duplicate, table full.
    ids = '0;
    ids[0] = 8'h12;
    txn(4'b0001, ids, 1'b1, st); chk("plan_reg", 32'(st), 32'd0);
    txn(4'b0001, ids, 1'b1, st); chk("plan_dup", 32'(st), 32'd1);
    ids[0] = 8'h34;
    txn(4'b0001, ids, 1'b0, st); chk("plan_full", 32'(st), 32'd2);

    // All requesters held valid: strict rotation, grants only from IDLE.
    do_reset();
    space_en = 1'b0;
    for (int i = 0; i < NR; i++) ids[i] = IW'(8'h50 + i);
    rq.in_req_id = ids;
    rq.in_req_valid = '1;
    rot[0] = 0; rot[1] = 1; rot[2] = 2; rot[3] = 3; rot[4] = 0;
    gap = 0;
    for (int n = 0; n < 5; n++) begin
      seen = 0;
      for (int c = 0; c < 8 && seen == 0; c++) begin
        @(negedge nocclk);
        if (rq.out_req_ready != '0) seen = 1;
        else begin
          @(posedge nocclk); #1;
          gap++;
        end
      end
      chk("rot_gnt", 32'(rq.out_req_ready), 32'(1 << rot[n]));
      if (n > 0) chk("rot_gap", 32'(gap >= 2), 32'd1);
      gap = 0;
      @(posedge nocclk); #1;
    end
    rq.in_req_valid = '0;
    space_en = 1'b1;

    // Random traffic against the table model.
    do_reset();
    clr_tbl();
    for (int n = 0; n < 40; n++) begin
      if (n == 20) clr_tbl();
      for (int i = 0; i < NR; i++) ids[i] = IW'($urandom_range(0, 15));
      txn(NR'($urandom_range(1, (1 << NR) - 1)), ids, ($urandom_range(0, 3) != 0), st);
    end

    // FIFO: overflow on a fifth push, then drain in order.
    do_reset();
    for (int i = 1; i <= 5; i++) evt_step(1'b1, IW'(i), (i == 3), 1'b0);
    chk("ovf_set", 32'(out_evt_overflow), 32'd1);
    for (int i = 0; i < 5; i++) evt_step(1'b0, '0, 1'b0, 1'b1);
    chk("drained", 32'(out_evt_valid), 32'd0);

    // FIFO: push and pop together while full is lossless.
    do_reset();
    for (int i = 1; i <= 4; i++) evt_step(1'b1, IW'(i), 1'b0, 1'b0);
    evt_step(1'b1, 8'd5, 1'b1, 1'b1);
    evt_step(1'b0, '0, 1'b0, 1'b0);
    chk("full_pp_ovf", 32'(out_evt_overflow), 32'd0);
    for (int i = 0; i < 5; i++) evt_step(1'b0, '0, 1'b0, 1'b1);

    // FIFO random push/pop.
    do_reset();
    for (int n = 0; n < 80; n++)
      evt_step($urandom_range(0, 2) != 0, IW'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0);

    // Reset in REGISTER: no done, back to IDLE, rotation and FIFO restart.
    do_reset();
    clr_tbl();
    evt_step(1'b1, 8'h77, 1'b1, 1'b0);
    evt_step(1'b1, 8'h78, 1'b0, 1'b0);
    ids = '0;
    ids[1] = 8'h40;
    rq.in_req_id = ids;
    rq.in_req_valid = 4'b0010;
    space_en = 1'b1;
    @(negedge nocclk);
    chk("mr_grant", 32'(rq.out_req_ready), 32'd2);
    @(posedge nocclk); #1;
    rq.in_req_valid = '0;
    @(posedge nocclk); #1;
    @(negedge nocclk);
    chk("mr_regv", 32'(out_register_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge nocclk); #1;
    rst_n = 1'b1;
    tbl[8'h40] = 1'b1;
    tbl_cnt = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge nocclk);
      chk("mr_done", 32'(rq.out_req_done), 32'd0);
      chk("mr_regv0", 32'(out_register_valid), 32'd0);
      chk("mr_evtv", 32'(out_evt_valid), 32'd0);
      chk("mr_ovf", 32'(out_evt_overflow), 32'd0);
      @(posedge nocclk); #1;
    end
    last_g = NR - 1;
    evq.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < NR; i++) ids[i] = IW'(8'h60 + i);
    txn('1, ids, 1'b1, st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
